// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter between I-cache and D-cache miss ports onto one memory bus.
// The winning request is latched and held until m_ready, or until the watchdog expires.
module cache_mem_arbiter #(
    parameter int A_WIDTH = 32,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               clrn,
    input  logic [A_WIDTH-1:0] ic_a,
    input  logic               ic_strobe,
    output logic [31:0]        ic_dout,
    output logic               ic_ready,
    input  logic [A_WIDTH-1:0] dc_a,
    input  logic [31:0]        dc_din,
    input  logic               dc_rw,
    input  logic               dc_strobe,
    output logic [31:0]        dc_dout,
    output logic               dc_ready,
    output logic [A_WIDTH-1:0] m_a,
    output logic [31:0]        m_din,
    output logic               m_rw,
    output logic               m_strobe,
    input  logic [31:0]        m_dout,
    input  logic               m_ready,
    output logic               timeout_err,
    output logic               grant_d
);

    // state  | meaning
    // IDLE   | waiting for a strobe; grants and latches the request
    // SERV_I | I-cache transaction on the memory bus
    // SERV_D | D-cache transaction on the memory bus
    // DONE   | dead cycle so a stale strobe is not re-granted
    typedef enum logic [1:0] {IDLE, SERV_I, SERV_D, DONE} state_t;

    state_t             state_q, state_d;
    logic               last_d_q, last_d_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [A_WIDTH-1:0] a_q, a_d;
    logic [31:0]        din_q, din_d;
    logic               rw_q, rw_d;
    logic               terr_q, terr_d;

    logic               gnt_i, gnt_d;
    logic               expired;
    logic               finish;
    logic [31:0]        rdata;

    // On a tie the requester not served last wins; last_d resets to 0 so D wins first.
    assign gnt_d   = dc_strobe && (!ic_strobe || !last_d_q);
    assign gnt_i   = ic_strobe && (!dc_strobe || last_d_q);
    assign expired = (cnt_q == CNT_W'(TIMEOUT));
    assign finish  = m_ready || expired;
    assign rdata   = m_ready ? m_dout : 32'h0;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
            cnt_q    <= '0;
            a_q      <= '0;
            din_q    <= '0;
            rw_q     <= 1'b0;
            terr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            din_q    <= din_d;
            rw_q     <= rw_d;
            terr_q   <= terr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        din_d    = din_q;
        rw_d     = rw_q;
        terr_d   = terr_q;
        m_strobe = 1'b0;
        m_rw     = 1'b0;
        ic_ready = 1'b0;
        dc_ready = 1'b0;
        ic_dout  = 32'h0;
        dc_dout  = 32'h0;

        case (state_q)
            IDLE: begin
                if (gnt_d) begin
                    state_d  = SERV_D;
                    a_d      = dc_a;
                    din_d    = dc_din;
                    rw_d     = dc_rw;
                    cnt_d    = '0;
                    last_d_d = 1'b1;
                end else if (gnt_i) begin
                    state_d  = SERV_I;
                    a_d      = ic_a;
                    din_d    = 32'h0;
                    rw_d     = 1'b0;
                    cnt_d    = '0;
                    last_d_d = 1'b0;
                end
            end
            SERV_I, SERV_D: begin
                m_strobe = 1'b1;
                m_rw     = rw_q;
                if (state_q == SERV_I) begin
                    ic_ready = finish;
                    ic_dout  = finish ? rdata : 32'h0;
                end else begin
                    dc_ready = finish;
                    dc_dout  = finish ? rdata : 32'h0;
                end
                // A real answer in the expiry cycle takes priority over the watchdog.
                if (m_ready) begin
                    state_d = DONE;
                end else if (expired) begin
                    terr_d  = 1'b1;
                    state_d = DONE;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign m_a         = a_q;
    assign m_din       = din_q;
    assign grant_d     = last_d_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter, built with TIMEOUT=4 so the watchdog is reachable.
module tb_cache_mem_arbiter;

    logic        clk = 1'b0;
    logic        clrn;
    logic [31:0] ic_a, dc_a, dc_din, m_dout;
    logic        ic_strobe, dc_rw, dc_strobe, m_ready;
    logic [31:0] ic_dout, dc_dout, m_a, m_din;
    logic        ic_ready, dc_ready, m_rw, m_strobe, timeout_err, grant_d;

    int checks = 0;
    int errors = 0;

    cache_mem_arbiter #(.A_WIDTH(32), .TIMEOUT(4), .CNT_W(8)) dut (
        .clk(clk), .clrn(clrn),
        .ic_a(ic_a), .ic_strobe(ic_strobe), .ic_dout(ic_dout), .ic_ready(ic_ready),
        .dc_a(dc_a), .dc_din(dc_din), .dc_rw(dc_rw), .dc_strobe(dc_strobe),
        .dc_dout(dc_dout), .dc_ready(dc_ready),
        .m_a(m_a), .m_din(m_din), .m_rw(m_rw), .m_strobe(m_strobe),
        .m_dout(m_dout), .m_ready(m_ready),
        .timeout_err(timeout_err), .grant_d(grant_d)
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        clrn = 1'b0; ic_strobe = 0; dc_strobe = 0; dc_rw = 0; m_ready = 0;
        ic_a = 0; dc_a = 0; dc_din = 0; m_dout = 0;
        step(); step(); #1;
        checks++;
        if ({m_strobe, m_rw, ic_ready, dc_ready, grant_d, timeout_err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b exp 000000",
                     {m_strobe, m_rw, ic_ready, dc_ready, grant_d, timeout_err});
        end
        checks++;
        if (m_a !== 32'h0 || m_din !== 32'h0) begin
            errors++; $display("FAIL reset_latch: m_a %h m_din %h exp 0", m_a, m_din);
        end
        step(); clrn = 1'b1;
    endtask

    task automatic test_icache_read();
        int hi = 0;
        step(); ic_strobe = 1; ic_a = 32'h1FC0_0010; #1;
        checks++;
        if (m_strobe !== 1'b0) begin errors++; $display("FAIL ird_idle: m_strobe %b exp 0", m_strobe); end
        for (int c = 1; c <= 3; c++) begin
            step(); m_ready = (c == 3); m_dout = (c == 3) ? 32'hDEAD_BEEF : 32'h1111_1111; #1;
            if (m_strobe === 1'b1) hi++;
            checks++;
            if (m_a !== 32'h1FC0_0010 || m_rw !== 1'b0) begin
                errors++; $display("FAIL ird_bus c%0d: m_a %h m_rw %b exp 1fc00010 0", c, m_a, m_rw);
            end
            checks++;
            if (ic_ready !== (c == 3) || dc_ready !== 1'b0) begin
                errors++; $display("FAIL ird_ready c%0d: ic %b dc %b exp %0d 0", c, ic_ready, dc_ready, c == 3);
            end
        end
        checks++;
        if (ic_dout !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ird_data: got %h exp deadbeef", ic_dout); end
        checks++;
        if (hi !== 3) begin errors++; $display("FAIL ird_strobe_len: got %0d exp 3", hi); end
        step(); ic_strobe = 0; m_ready = 0; #1;
        checks++;
        if (m_strobe !== 1'b0 || ic_ready !== 1'b0) begin
            errors++; $display("FAIL ird_done: m_strobe %b ic_ready %b exp 0 0", m_strobe, ic_ready);
        end
        step();
    endtask

    task automatic test_back_to_back();
        step(); clrn = 0; step(); clrn = 1;
        for (int i = 0; i < 12; i++) begin
            bit srv, exp_d;
            step(); ic_strobe = 1; dc_strobe = 1; m_ready = 1; m_dout = 32'h1000 + i;
            ic_a = 32'hA0; dc_a = 32'hB0; dc_rw = 0; #1;
            srv = (i % 3 == 1);
            exp_d = ((i / 3) % 2 == 0);
            checks++;
            if (m_strobe !== srv) begin errors++; $display("FAIL b2b_strobe i%0d: got %b exp %b", i, m_strobe, srv); end
            if (srv) begin
                checks++;
                if (grant_d !== exp_d || dc_ready !== exp_d || ic_ready !== !exp_d) begin
                    errors++;
                    $display("FAIL b2b_grant i%0d: grant_d %b dc %b ic %b exp_d %b", i, grant_d, dc_ready, ic_ready, exp_d);
                end
                checks++;
                if ((exp_d ? dc_dout : ic_dout) !== 32'h1000 + i || m_a !== (exp_d ? 32'hB0 : 32'hA0)) begin
                    errors++; $display("FAIL b2b_data i%0d: dout %h m_a %h", i, exp_d ? dc_dout : ic_dout, m_a);
                end
            end else begin
                checks++;
                if (ic_ready !== 1'b0 || dc_ready !== 1'b0) begin
                    errors++; $display("FAIL b2b_idle_ready i%0d: ic %b dc %b exp 0 0", i, ic_ready, dc_ready);
                end
            end
        end
        step(); ic_strobe = 0; dc_strobe = 0; m_ready = 0;
        step();
    endtask

    task automatic test_dcache_write();
        step(); dc_strobe = 1; dc_rw = 1; dc_a = 32'h40; dc_din = 32'h1234_5678; m_ready = 0;
        for (int c = 1; c <= 3; c++) begin
            step(); dc_a = 32'hFFFF_0000; dc_din = 32'hCAFE_F00D; dc_rw = 0; m_ready = (c == 3); #1;
            checks++;
            if (m_strobe !== 1'b1 || m_a !== 32'h40 || m_din !== 32'h1234_5678 || m_rw !== 1'b1) begin
                errors++;
                $display("FAIL dwr_bus c%0d: strobe %b m_a %h m_din %h m_rw %b", c, m_strobe, m_a, m_din, m_rw);
            end
            checks++;
            if (dc_ready !== (c == 3)) begin errors++; $display("FAIL dwr_ready c%0d: got %b exp %0d", c, dc_ready, c == 3); end
        end
        step(); dc_strobe = 0; m_ready = 0; #1;
        checks++;
        if (m_strobe !== 1'b0 || m_rw !== 1'b0 || m_a !== 32'h40 || dc_ready !== 1'b0) begin
            errors++; $display("FAIL dwr_done: strobe %b m_rw %b m_a %h dc_ready %b", m_strobe, m_rw, m_a, dc_ready);
        end
        step();
    endtask

    task automatic test_watchdog_collision();
        step(); dc_strobe = 1; dc_rw = 0; dc_a = 32'h80; m_ready = 0;
        for (int c = 1; c <= 5; c++) begin
            step(); m_ready = (c == 5); m_dout = (c == 5) ? 32'hA5A5_A5A5 : 32'h0; #1;
            checks++;
            if (dc_ready !== (c == 5)) begin errors++; $display("FAIL wcol_ready c%0d: got %b exp %0d", c, dc_ready, c == 5); end
        end
        checks++;
        if (dc_dout !== 32'hA5A5_A5A5) begin errors++; $display("FAIL wcol_data: got %h exp a5a5a5a5", dc_dout); end
        step(); dc_strobe = 0; m_ready = 0; #1;
        checks++;
        if (timeout_err !== 1'b0) begin errors++; $display("FAIL wcol_err: got %b exp 0", timeout_err); end
        step();
    endtask

    task automatic test_watchdog_expiry();
        step(); dc_strobe = 1; dc_rw = 0; dc_a = 32'hC0; m_ready = 0; m_dout = 32'h5555_5555;
        for (int c = 1; c <= 5; c++) begin
            step(); #1;
            checks++;
            if (dc_ready !== (c == 5) || m_strobe !== 1'b1) begin
                errors++; $display("FAIL wdog_ready c%0d: dc_ready %b strobe %b exp %0d 1", c, dc_ready, m_strobe, c == 5);
            end
        end
        checks++;
        if (dc_dout !== 32'h0) begin errors++; $display("FAIL wdog_data: got %h exp 0", dc_dout); end
        step(); dc_strobe = 0; #1;
        checks++;
        if (timeout_err !== 1'b1 || m_strobe !== 1'b0) begin
            errors++; $display("FAIL wdog_err: err %b strobe %b exp 1 0", timeout_err, m_strobe);
        end
        step(); dc_strobe = 1; dc_rw = 1; dc_a = 32'hD0; dc_din = 32'h7;
        for (int c = 1; c <= 2; c++) begin
            step(); m_ready = (c == 2); #1;
            checks++;
            if (dc_ready !== (c == 2)) begin errors++; $display("FAIL wdog_next c%0d: got %b exp %0d", c, dc_ready, c == 2); end
        end
        step(); dc_strobe = 0; m_ready = 0; #1;
        checks++;
        if (timeout_err !== 1'b1) begin errors++; $display("FAIL wdog_sticky: got %b exp 1", timeout_err); end
        step();
    endtask

    task automatic test_reset_mid();
        step(); ic_strobe = 1; ic_a = 32'h2000;
        step(); #1;
        checks++;
        if (m_strobe !== 1'b1 || grant_d !== 1'b0) begin
            errors++; $display("FAIL rmid_serv: strobe %b grant_d %b exp 1 0", m_strobe, grant_d);
        end
        step(); clrn = 0; m_ready = 1; m_dout = 32'hFFFF_FFFF; #1;
        checks++;
        if ({m_strobe, ic_ready, dc_ready, timeout_err, grant_d, m_rw} !== 6'b0 || m_a !== 32'h0) begin
            errors++;
            $display("FAIL rmid_reset: ctrl %b m_a %h exp 000000 0",
                     {m_strobe, ic_ready, dc_ready, timeout_err, grant_d, m_rw}, m_a);
        end
        step(); ic_strobe = 0; #1;
        checks++;
        if (ic_ready !== 1'b0) begin errors++; $display("FAIL rmid_noready: got %b exp 0", ic_ready); end
        step(); clrn = 1; m_ready = 0; ic_strobe = 1; dc_strobe = 1; dc_rw = 0; dc_a = 32'hE0; #1;
        checks++;
        if (m_strobe !== 1'b0) begin errors++; $display("FAIL rmid_idle: strobe %b exp 0", m_strobe); end
        step(); #1;
        checks++;
        if (m_strobe !== 1'b1 || grant_d !== 1'b1 || m_a !== 32'hE0) begin
            errors++; $display("FAIL rmid_tie: strobe %b grant_d %b m_a %h exp 1 1 e0", m_strobe, grant_d, m_a);
        end
    endtask

    initial begin
        test_reset();
        test_icache_read();
        test_back_to_back();
        test_dcache_write();
        test_watchdog_collision();
        test_watchdog_expiry();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Two-requester memory-port arbiter placed between the instruction cache, the data cache and the single shared memory bus. Each cache's memory-side strobe/ready interface is arbitrated round-robin. The winning request's address, write data and direction are latched and held on the bus until `m_ready`. A watchdog forces completion and flags an error if the memory never answers.

## Interface
- `A_WIDTH`, 32: address width.
- `TIMEOUT`, 255: maximum wait cycles per transaction before a forced completion (1..2^CNT_W-1).
- `CNT_W`, 8: width of the wait counter.

- `clk` in 1: single clock, all state on rising edge.
- `clrn` in 1: reset, asynchronous, active-low.
- `ic_a` in A_WIDTH: I-cache miss address.
- `ic_strobe` in 1: I-cache request (read only), held until `ic_ready`.
- `ic_dout` out 32: read data to I-cache.
- `ic_ready` out 1: one-cycle completion pulse to I-cache.
- `dc_a` in A_WIDTH: D-cache address.
- `dc_din` in 32: D-cache write data.
- `dc_rw` in 1: 0 read, 1 write.
- `dc_strobe` in 1: D-cache request, held until `dc_ready`.
- `dc_dout` out 32: read data to D-cache.
- `dc_ready` out 1: one-cycle completion pulse to D-cache.
- `m_a` out A_WIDTH: memory address.
- `m_din` out 32: memory write data.
- `m_rw` out 1: memory direction, 1 write.
- `m_strobe` out 1: memory request.
- `m_dout` in 32: memory read data.
- `m_ready` in 1: memory completion, valid for one cycle.
- `timeout_err` out 1: sticky watchdog flag.
- `grant_d` out 1: current/last grant owner, 1 = D-cache.

## Operation
- FSM states are `IDLE`, `SERV_I`, `SERV_D` and `DONE`.
- **IDLE**
  - Neither strobe high: stay in `IDLE`.
  - Only one strobe high: grant that requester.
  - Both strobes high: grant the requester not served last. The `last_d` register resets to 0, so D-cache wins the first tie.
  - On a grant, latch into registers: `ic_a`/`dc_a`; `dc_din` (0 for I); `dc_rw` (0 for I). Clear `wait_cnt` and update `last_d`.
- **SERV_x**
  - `m_strobe`=1; `m_a`/`m_din`/`m_rw` driven from the latches and stable for the whole transaction.
  - When `m_ready`=1:
    - `x_ready`=1 combinationally in the same cycle.
    - `x_dout`=`m_dout` (pass-through).
    - Next state is `DONE`.
  - When `m_ready`=0:
    - If `wait_cnt`==TIMEOUT: `x_ready`=1, `x_dout`=32'h0, set `timeout_err`, next state `DONE`.
    - Otherwise `wait_cnt`+1, saturating at the counter width.
- **DONE**
  - One dead cycle: `m_strobe`=0, no ready pulses, no grant. Stale strobes from the just-served cache are not re-granted.
  - Next state is `IDLE`.
- The requester whose strobe drops mid-service is ignored. The memory transaction runs to completion and the ready pulse is still issued.
- The non-granted requester's `x_ready`=0 and `x_dout`=32'h0.
- `timeout_err` is cleared only by `clrn`.
- `grant_d` reflects `last_d`.
- Outputs outside `SERV_x`: `m_strobe`=0, `m_rw`=0, `m_a`/`m_din` hold the last latched values.

## Timing
- Reset values (async on `clrn`=0):
  - state=`IDLE`, `last_d`=0, `wait_cnt`=0.
  - Latches=0, `timeout_err`=0.
  - `m_strobe`=`m_rw`=`ic_ready`=`dc_ready`=0, `grant_d`=0.
- Reset mid-transaction aborts to `IDLE` with no ready pulse. Requesters are reset by the same `clrn`.
- Request sampled high at edge N -> `m_strobe` high from cycle after edge N.
- `m_ready` returned k cycles after `m_strobe` rises (k≥0; same-cycle allowed) -> `x_ready` in that cycle.
- Total occupancy per transaction: 1 (grant) + k+1 (serve) + 1 (`DONE`).
- Back-to-back grants are at least 3 cycles apart (`SERV`→`DONE`→`IDLE`→`SERV`).
- Watchdog: forced completion in the (TIMEOUT+1)-th `SERV` cycle.
- `m_ready` and a watchdog expiry in the same cycle: `m_ready` wins. Real data is returned and `timeout_err` is not set.
- `m_ready` arriving outside `SERV` is ignored.

## Test plan
- **I-cache read.** `ic_strobe`=1, `ic_a`=0x1FC0_0010, memory answers 2 cycles after `m_strobe` with 0xDEAD_BEEF -> `m_strobe` high for 3 cycles, `m_rw`=0, `ic_ready` single pulse with `ic_dout`=0xDEAD_BEEF, `m_strobe` low in the following cycle.
- **Simultaneous requests.** Both strobes held continuously from reset, zero-wait memory -> grant order D, I, D, I. `grant_d` toggles 1,0,1,0. Consecutive `m_strobe` rises are exactly 3 cycles apart.
- **D-cache write with changing inputs.** `dc_rw`=1, `dc_a`=0x0000_0040, `dc_din`=0x1234_5678; inputs changed to other values one cycle after grant -> `m_a`/`m_din`/`m_rw` stay 0x40/0x1234_5678/1 until `m_ready`, then `dc_ready` pulses.
- **Watchdog expiry.** TIMEOUT=4, `m_ready` never asserted -> `dc_ready` pulses in the 5th `SERV` cycle with `dc_dout`=0, `timeout_err`=1 and stays 1 across later successful transactions.
- **Watchdog collision.** TIMEOUT=4, `m_ready` asserted exactly in the 5th `SERV` cycle with data 0xA5A5_A5A5 -> `dc_dout`=0xA5A5_A5A5, `timeout_err` stays 0.
- **Reset mid-operation.** `clrn` pulsed low during `SERV_I` -> outputs immediately at reset values, no `ic_ready`, and the next tie after release goes to D-cache.
